sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arbiter.sv | 131 +++++++++++++
 tb/tb_sp_ram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arbiter
// Description : Two-requester, zero-wait arbiter in front of a single-port RAM
//               with one-cycle read latency. Define SP_RAM_ARB_ROUND_ROBIN_EN
//               for round-robin contention; otherwise port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic [1:0]                  req_i,
    output logic [1:0]                  gnt_o,
    output logic [1:0]                  rvalid_o,
    input  logic [2*ADDR_WIDTH-1:0]     addr_i,
    input  logic [1:0]                  we_i,
    input  logic [2*(DATA_WIDTH/8)-1:0] be_i,
    input  logic [2*DATA_WIDTH-1:0]     wdata_i,
    output logic [DATA_WIDTH-1:0]       rdata_o,

    output logic                        mem_req_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    output logic                        mem_we_o,
    output logic [DATA_WIDTH/8-1:0]     mem_be_o,
    output logic [DATA_WIDTH-1:0]       mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]       mem_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_owner;
    logic [1:0] w_req;
    logic [1:0] w_gnt;

    // Reset masks requests so nothing is granted (and no response is owed)
    // in a cycle where reset is being sampled.
    assign w_req = rst_i ? 2'b00 : req_i;

`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
    // Index of the most recently granted port; 1 after reset so port 0 wins first.
    logic r_last_grant;

    always_comb begin
        w_gnt = w_req;
        if (&w_req) begin
            w_gnt = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= 1'b1;
        end else if (|w_gnt) begin
            r_last_grant <= w_gnt[1];
        end
    end
`else
    always_comb begin
        w_gnt = w_req;
        if (&w_req) begin
            w_gnt = 2'b01;
        end
    end
`endif

    assign gnt_o     = w_gnt;
    assign mem_req_o = |w_gnt;

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_gnt[0]) begin
            mem_addr_o  = addr_i[0 +: ADDR_WIDTH];
            mem_we_o    = we_i[0];
            mem_be_o    = be_i[0 +: BE_WIDTH];
            mem_wdata_o = wdata_i[0 +: DATA_WIDTH];
        end else if (w_gnt[1]) begin
            mem_addr_o  = addr_i[ADDR_WIDTH +: ADDR_WIDTH];
            mem_we_o    = we_i[1];
            mem_be_o    = be_i[BE_WIDTH +: BE_WIDTH];
            mem_wdata_o = wdata_i[DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Response tracker: owner records which port is due a response next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_state <= ST_RESP;
                        r_owner <= w_gnt;
                    end
                end
                ST_RESP: begin
                    if (|w_gnt) begin
                        r_state <= ST_RESP;
                        r_owner <= w_gnt;
                    end else begin
                        r_state <= ST_IDLE;
                        r_owner <= 2'b00;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_owner <= 2'b00;
                end
            endcase
        end
    end

    assign rvalid_o = (r_state == ST_RESP) ? r_owner : 2'b00;
    assign rdata_o  = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_arbiter
// Description : Scoreboard bench for sp_ram_arbiter with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [2*AW-1:0] addr;
    logic [1:0]    we;
    logic [2*BW-1:0] be;
    logic [2*DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Single-port RAM, one-cycle read latency.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int i = 0; i < BW; i++)
                    if (mem_be[i]) ram[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic [1:0]    port;
        logic          wr;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         sb[$];
    logic [DW-1:0] shadow [256];
    logic          m_last;
    logic [1:0]    prev_g;
    logic          rv_known;
    int            checks = 0;
    int            errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] model_gnt(input logic r, input logic [1:0] q);
        if (r) return 2'b00;
        if (q != 2'b11) return q;
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
        return m_last ? 2'b01 : 2'b10;
`else
        return 2'b01;
`endif
    endfunction

    task automatic step(input logic r, input logic [1:0] q, input logic [1:0] w,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [1:0]    g;
        logic          p;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        logic [DW-1:0] ed;
        resp_t         e;
        @(posedge clk);
        #1;
        rst = r; req = q; we = w;
        addr = {a1, a0}; be = {b1, b0}; wdata = {d1, d0};
        @(negedge clk);

        // Responses for the previous cycle's grant.
        if (rv_known) begin
            check_eq("rvalid", rvalid, prev_g);
            if (rvalid != 2'b00) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_eq("rv_port", rvalid, e.port);
                    if (!e.wr) check_eq("rdata", rdata, e.data);
                end
            end
        end

        g = model_gnt(r, q);
        p = g[1];
        ea = (g == 2'b00) ? '0 : (p ? a1 : a0);
        eb = (g == 2'b00) ? '0 : (p ? b1 : b0);
        ed = (g == 2'b00) ? '0 : (p ? d1 : d0);
        check_eq("gnt", gnt, g);
        check_eq("mem_req", mem_req, |g);
        check_eq("mem_addr", mem_addr, ea);
        check_eq("mem_we", mem_we, (g == 2'b00) ? 1'b0 : w[p]);
        check_eq("mem_be", mem_be, eb);
        check_eq("mem_wdata", mem_wdata, ed);

        if (g != 2'b00) begin
            e.port = g;
            e.wr   = w[p];
            e.data = shadow[ea[7:0]];
            sb.push_back(e);
            if (w[p])
                for (int i = 0; i < BW; i++)
                    if (eb[i]) shadow[ea[7:0]][8*i +: 8] = ed[8*i +: 8];
            m_last = p;
        end
        if (r) begin
            m_last   = 1'b1;
            rv_known = 1'b1;
        end
        prev_g = g;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        m_last = 1'b1; prev_g = 2'b00; rv_known = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'hA500_0000 ^ (i * 32'h0101_0101);
            shadow[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
        end

        // Reset, including a contending request that must not be granted.
        step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        step(1'b1, 2'b11, 2'b00, 32'h1, 32'h2, 4'hF, 4'hF, '0, '0);
        idle(2);

        // Port 0 reads 0x10 alone.
        step(1'b0, 2'b01, 2'b00, 32'h10, 32'h0, 4'hF, 4'h0, '0, '0);
        idle(1);

        // Both ports contend for six cycles.
        for (int i = 0; i < 6; i++)
            step(1'b0, 2'b11, 2'b00, 32'h30 + i, 32'h40 + i, 4'hF, 4'hF, '0, '0);
        idle(1);

        // Port 1 writes, port 0 reads it back the very next cycle.
        step(1'b0, 2'b10, 2'b10, 32'h0, 32'h20, 4'h0, 4'hF, '0, 32'hDEAD_BEEF);
        step(1'b0, 2'b01, 2'b00, 32'h20, 32'h0, 4'hF, 4'h0, '0, '0);

        // Partial byte-enable write followed by readback.
        step(1'b0, 2'b01, 2'b01, 32'h21, 32'h0, 4'b0101, 4'h0, 32'h1122_3344, '0);
        step(1'b0, 2'b10, 2'b00, 32'h0, 32'h21, 4'h0, 4'hF, '0, '0);

        // Alternating single requesters back-to-back: no idle bubble.
        for (int i = 0; i < 6; i++)
            step(1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 32'h50 + i, 32'h60 + i, 4'hF, 4'hF, '0, '0);

        // Grant to port 0, then reset arrives with a live request.
        step(1'b0, 2'b01, 2'b00, 32'h70, 32'h0, 4'hF, 4'h0, '0, '0);
        step(1'b1, 2'b01, 2'b00, 32'h71, 32'h0, 4'hF, 4'h0, '0, '0);
        step(1'b0, 2'b11, 2'b00, 32'h72, 32'h73, 4'hF, 4'hF, '0, '0);
        step(1'b0, 2'b11, 2'b00, 32'h74, 32'h75, 4'hF, 4'hF, '0, '0);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 60; i++)
            step(1'b0, 2'($urandom), 2'($urandom),
                 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                 4'($urandom), 4'($urandom), $urandom, $urandom);
        idle(3);

        check_eq("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
